// File: rtl/sdi_xcvr_pkg.sv
// Shared state encodings and default timing for the SDI transceiver reset sequencer.
package sdi_xcvr_pkg;

  localparam int SYNC_STAGES      = 2;
  localparam int DEF_T_DIG        = 32;
  localparam int DEF_LTD_CYCLES   = 1024;
  localparam int DEF_LOCK_TIMEOUT = 65536;

  typedef enum logic [2:0] {
    TX_CAL_WAIT = 3'd0,
    TX_ANA_REL  = 3'd1,
    TX_DIG_WAIT = 3'd2,
    TX_DIG_REL  = 3'd3,
    TX_READY    = 3'd4
  } tx_state_t;

  typedef enum logic [2:0] {
    RX_CAL_WAIT = 3'd0,
    RX_ANA_REL  = 3'd1,
    RX_LTD_WAIT = 3'd2,
    RX_DIG_WAIT = 3'd3,
    RX_DIG_REL  = 3'd4,
    RX_READY    = 3'd5
  } rx_state_t;

endpackage

// File: rtl/sdi_xcvr_rx_rst_fsm.sv
// One RX channel: status synchronisers, lock-stability/timeout counters and reset FSM.
module sdi_xcvr_rx_rst_fsm
  import sdi_xcvr_pkg::*;
#(
  parameter int T_DIG        = DEF_T_DIG,
  parameter int LTD_CYCLES   = DEF_LTD_CYCLES,
  parameter int LOCK_TIMEOUT = DEF_LOCK_TIMEOUT,
  parameter int CNT_W        = $clog2(DEF_LOCK_TIMEOUT + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic cal_busy,
  input  logic ana_stat,
  input  logic dig_stat,
  input  logic locked,
  output logic ana_rst,
  output logic dig_rst,
  output logic ready,
  output logic lock_loss
);

  localparam logic [CNT_W-1:0] LTD_M1 = CNT_W'(LTD_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIG_M1 = CNT_W'(T_DIG - 1);
  localparam logic [CNT_W-1:0] TMO_M1 = CNT_W'(LOCK_TIMEOUT - 1);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

  logic [SYNC_STAGES-1:0] cal_sync, ana_sync, dig_sync, ltd_sync;
  logic cal_s, ana_s, dig_s, ltd_s;

  rx_state_t state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n, tmo, tmo_n;
  logic loss_n;

  // Synchroniser reset values assume the worst case: calibrating, in reset, unlocked.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cal_sync <= '1;
      ana_sync <= '1;
      dig_sync <= '1;
      ltd_sync <= '0;
    end else begin
      cal_sync <= {cal_sync[SYNC_STAGES-2:0], cal_busy};
      ana_sync <= {ana_sync[SYNC_STAGES-2:0], ana_stat};
      dig_sync <= {dig_sync[SYNC_STAGES-2:0], dig_stat};
      ltd_sync <= {ltd_sync[SYNC_STAGES-2:0], locked};
    end
  end

  assign cal_s = cal_sync[SYNC_STAGES-1];
  assign ana_s = ana_sync[SYNC_STAGES-1];
  assign dig_s = dig_sync[SYNC_STAGES-1];
  assign ltd_s = ltd_sync[SYNC_STAGES-1];

  always_comb begin
    state_n = state;
    cnt_n   = '0;
    tmo_n   = '0;
    loss_n  = 1'b0;
    case (state)
      RX_CAL_WAIT: if (!cal_s) state_n = RX_ANA_REL;
      RX_ANA_REL:  if (!ana_s) state_n = RX_LTD_WAIT;
      RX_LTD_WAIT: begin
        // A stable lock on the last allowed cycle still counts as success.
        if (ltd_s && cnt == LTD_M1) begin
          state_n = RX_DIG_WAIT;
        end else if (tmo == TMO_M1) begin
          state_n = RX_CAL_WAIT;
          loss_n  = 1'b1;
        end else begin
          cnt_n = ltd_s ? sat_inc(cnt) : '0;
          tmo_n = sat_inc(tmo);
        end
      end
      RX_DIG_WAIT: begin
        if (!ltd_s)             state_n = RX_LTD_WAIT;
        else if (cnt == DIG_M1) state_n = RX_DIG_REL;
        else                    cnt_n   = sat_inc(cnt);
      end
      RX_DIG_REL: if (!dig_s) state_n = RX_READY;
      RX_READY: begin
        if (!ltd_s) begin
          state_n = RX_LTD_WAIT;
          loss_n  = 1'b1;
        end
      end
      default: state_n = RX_CAL_WAIT;
    endcase
    if (cal_s && state != RX_CAL_WAIT) begin
      state_n = RX_CAL_WAIT;
      cnt_n   = '0;
      tmo_n   = '0;
      loss_n  = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= RX_CAL_WAIT;
      cnt       <= '0;
      tmo       <= '0;
      ana_rst   <= 1'b1;
      dig_rst   <= 1'b1;
      ready     <= 1'b0;
      lock_loss <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      tmo       <= tmo_n;
      ana_rst   <= (state_n == RX_CAL_WAIT);
      dig_rst   <= !(state_n == RX_DIG_REL || state_n == RX_READY);
      ready     <= (state == RX_READY) && (state_n == RX_READY);
      lock_loss <= loss_n;
    end
  end

endmodule

// File: rtl/sdi_xcvr_reset_seq.sv
// N-channel SDI PHY reset sequencer: shared TX FSM plus one independent RX FSM per channel.
module sdi_xcvr_reset_seq
  import sdi_xcvr_pkg::*;
#(
  parameter int NUM_CH       = 1,
  parameter int T_DIG        = DEF_T_DIG,
  parameter int LTD_CYCLES   = DEF_LTD_CYCLES,
  parameter int LOCK_TIMEOUT = DEF_LOCK_TIMEOUT,
  localparam int CNT_W       = $clog2(LOCK_TIMEOUT + 1)
) (
  input  logic              reconfig_clk,
  input  logic              reconfig_reset,
  input  logic              pll_locked,
  input  logic [NUM_CH-1:0] tx_cal_busy,
  input  logic [NUM_CH-1:0] rx_cal_busy,
  input  logic [NUM_CH-1:0] tx_analogreset_stat,
  input  logic [NUM_CH-1:0] tx_digitalreset_stat,
  input  logic [NUM_CH-1:0] rx_analogreset_stat,
  input  logic [NUM_CH-1:0] rx_digitalreset_stat,
  input  logic [NUM_CH-1:0] rx_is_lockedtodata,
  output logic [NUM_CH-1:0] tx_analogreset,
  output logic [NUM_CH-1:0] tx_digitalreset,
  output logic [NUM_CH-1:0] rx_analogreset,
  output logic [NUM_CH-1:0] rx_digitalreset,
  output logic              tx_ready,
  output logic [NUM_CH-1:0] rx_ready,
  output logic [NUM_CH-1:0] rx_lock_loss
);

  localparam int DIG_W = $clog2(T_DIG + 1);
  localparam logic [DIG_W-1:0] DIG_M1 = DIG_W'(T_DIG - 1);

  logic [SYNC_STAGES-1:0]             pll_sync;
  logic [SYNC_STAGES-1:0][NUM_CH-1:0] tx_cal_sync, tx_ana_sync, tx_dig_sync;
  logic pll_s, cal_idle, ana_done, dig_done;

  tx_state_t state, state_n;
  logic [DIG_W-1:0] dig_cnt, dig_cnt_n;

  always_ff @(posedge reconfig_clk or posedge reconfig_reset) begin
    if (reconfig_reset) begin
      pll_sync    <= '0;
      tx_cal_sync <= '1;
      tx_ana_sync <= '1;
      tx_dig_sync <= '1;
    end else begin
      pll_sync    <= {pll_sync[SYNC_STAGES-2:0], pll_locked};
      tx_cal_sync <= {tx_cal_sync[SYNC_STAGES-2:0], tx_cal_busy};
      tx_ana_sync <= {tx_ana_sync[SYNC_STAGES-2:0], tx_analogreset_stat};
      tx_dig_sync <= {tx_dig_sync[SYNC_STAGES-2:0], tx_digitalreset_stat};
    end
  end

  assign pll_s    = pll_sync[SYNC_STAGES-1];
  assign cal_idle = ~|tx_cal_sync[SYNC_STAGES-1];
  assign ana_done = ~|tx_ana_sync[SYNC_STAGES-1];
  assign dig_done = ~|tx_dig_sync[SYNC_STAGES-1];

  always_comb begin
    state_n   = state;
    dig_cnt_n = '0;
    case (state)
      TX_CAL_WAIT: if (pll_s && cal_idle) state_n = TX_ANA_REL;
      TX_ANA_REL:  if (ana_done) state_n = TX_DIG_WAIT;
      TX_DIG_WAIT: begin
        if (dig_cnt == DIG_M1) state_n   = TX_DIG_REL;
        else                   dig_cnt_n = dig_cnt + 1'b1;
      end
      TX_DIG_REL:  if (dig_done) state_n = TX_READY;
      TX_READY:    state_n = TX_READY;
      default:     state_n = TX_CAL_WAIT;
    endcase
    if (!pll_s && state != TX_CAL_WAIT) begin
      state_n   = TX_CAL_WAIT;
      dig_cnt_n = '0;
    end
  end

  // Outputs are decoded from the next state so they change cleanly on the clock edge.
  always_ff @(posedge reconfig_clk or posedge reconfig_reset) begin
    if (reconfig_reset) begin
      state           <= TX_CAL_WAIT;
      dig_cnt         <= '0;
      tx_analogreset  <= '1;
      tx_digitalreset <= '1;
      tx_ready        <= 1'b0;
    end else begin
      state           <= state_n;
      dig_cnt         <= dig_cnt_n;
      tx_analogreset  <= {NUM_CH{state_n == TX_CAL_WAIT}};
      tx_digitalreset <= {NUM_CH{!(state_n == TX_DIG_REL || state_n == TX_READY)}};
      tx_ready        <= (state == TX_READY) && (state_n == TX_READY);
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_rx
    sdi_xcvr_rx_rst_fsm #(
      .T_DIG        (T_DIG),
      .LTD_CYCLES   (LTD_CYCLES),
      .LOCK_TIMEOUT (LOCK_TIMEOUT),
      .CNT_W        (CNT_W)
    ) u_rx (
      .clk       (reconfig_clk),
      .rst       (reconfig_reset),
      .cal_busy  (rx_cal_busy[i]),
      .ana_stat  (rx_analogreset_stat[i]),
      .dig_stat  (rx_digitalreset_stat[i]),
      .locked    (rx_is_lockedtodata[i]),
      .ana_rst   (rx_analogreset[i]),
      .dig_rst   (rx_digitalreset[i]),
      .ready     (rx_ready[i]),
      .lock_loss (rx_lock_loss[i])
    );
  end

endmodule

// File: tb/tb_sdi_xcvr_reset_seq.sv
// Bench for sdi_xcvr_reset_seq: directed scenarios plus random lock/PLL/cal noise against a phase model.
module tb_sdi_xcvr_reset_seq;

  localparam int NCH = 2;
  localparam int TD  = 8;
  localparam int LTD = 16;
  localparam int TMO = 64;

  logic reconfig_clk = 1'b0;
  logic reconfig_reset;
  logic pll_locked;
  logic [NCH-1:0] tx_cal_busy, rx_cal_busy;
  logic [NCH-1:0] tx_analogreset_stat, tx_digitalreset_stat;
  logic [NCH-1:0] rx_analogreset_stat, rx_digitalreset_stat, rx_is_lockedtodata;
  logic [NCH-1:0] tx_analogreset, tx_digitalreset, rx_analogreset, rx_digitalreset;
  logic           tx_ready;
  logic [NCH-1:0] rx_ready, rx_lock_loss;

  sdi_xcvr_reset_seq #(
    .NUM_CH(NCH), .T_DIG(TD), .LTD_CYCLES(LTD), .LOCK_TIMEOUT(TMO)
  ) dut (
    .reconfig_clk         (reconfig_clk),
    .reconfig_reset       (reconfig_reset),
    .pll_locked           (pll_locked),
    .tx_cal_busy          (tx_cal_busy),
    .rx_cal_busy          (rx_cal_busy),
    .tx_analogreset_stat  (tx_analogreset_stat),
    .tx_digitalreset_stat (tx_digitalreset_stat),
    .rx_analogreset_stat  (rx_analogreset_stat),
    .rx_digitalreset_stat (rx_digitalreset_stat),
    .rx_is_lockedtodata   (rx_is_lockedtodata),
    .tx_analogreset       (tx_analogreset),
    .tx_digitalreset      (tx_digitalreset),
    .rx_analogreset       (rx_analogreset),
    .rx_digitalreset      (rx_digitalreset),
    .tx_ready             (tx_ready),
    .rx_ready             (rx_ready),
    .rx_lock_loss         (rx_lock_loss)
  );

  always #5 reconfig_clk = ~reconfig_clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: inputs seen two edges late, channel progress kept as phase numbers.
  typedef struct packed {
    logic pll;
    logic [NCH-1:0] tcal, rcal, tas, tds, ras, rds, lk;
  } in_t;

  in_t pipe [2];
  int  tx_ph, tx_t;
  int  rx_ph [NCH];
  int  streak [NCH];
  int  waited [NCH];
  int  rx_t [NCH];
  logic [NCH-1:0] e_tx_ana, e_tx_dig, e_rx_ana, e_rx_dig, e_rx_rdy, e_loss;
  logic           e_tx_rdy;

  function automatic in_t idle_in();
    in_t r;
    r.pll = 1'b0; r.tcal = '1; r.rcal = '1; r.tas = '1; r.tds = '1;
    r.ras = '1; r.rds = '1; r.lk = '0;
    return r;
  endfunction

  function automatic in_t cur_in();
    in_t r;
    r.pll = pll_locked; r.tcal = tx_cal_busy; r.rcal = rx_cal_busy;
    r.tas = tx_analogreset_stat; r.tds = tx_digitalreset_stat;
    r.ras = rx_analogreset_stat; r.rds = rx_digitalreset_stat; r.lk = rx_is_lockedtodata;
    return r;
  endfunction

  task automatic model_reset();
    pipe[0] = idle_in(); pipe[1] = idle_in();
    tx_ph = 0; tx_t = 0;
    for (int i = 0; i < NCH; i++) begin
      rx_ph[i] = 0; streak[i] = 0; waited[i] = 0; rx_t[i] = 0;
    end
    e_tx_ana = '1; e_tx_dig = '1; e_rx_ana = '1; e_rx_dig = '1;
    e_tx_rdy = 1'b0; e_rx_rdy = '0; e_loss = '0;
  endtask

  task automatic model_step();
    in_t u;
    int  old;
    u = pipe[1]; pipe[1] = pipe[0]; pipe[0] = cur_in();
    old = tx_ph;
    if (tx_ph != 0 && !u.pll) tx_ph = 0;
    else case (tx_ph)
      0: if (u.pll && u.tcal == '0) tx_ph = 1;
      1: if (u.tas == '0) begin tx_ph = 2; tx_t = 0; end
      2: begin tx_t++; if (tx_t == TD) tx_ph = 3; end
      3: if (u.tds == '0) tx_ph = 4;
      default: ;
    endcase
    e_tx_rdy = (old == 4 && tx_ph == 4);
    e_tx_ana = {NCH{tx_ph == 0}};
    e_tx_dig = {NCH{tx_ph < 3}};
    for (int i = 0; i < NCH; i++) begin
      old = rx_ph[i];
      e_loss[i] = 1'b0;
      if (rx_ph[i] != 0 && u.rcal[i]) rx_ph[i] = 0;
      else case (rx_ph[i])
        0: if (!u.rcal[i]) rx_ph[i] = 1;
        1: if (!u.ras[i]) begin rx_ph[i] = 2; streak[i] = 0; waited[i] = 0; end
        2: begin
          waited[i]++;
          streak[i] = u.lk[i] ? streak[i] + 1 : 0;
          if (streak[i] >= LTD) begin rx_ph[i] = 3; rx_t[i] = 0; end
          else if (waited[i] >= TMO) begin rx_ph[i] = 0; e_loss[i] = 1'b1; end
        end
        3: begin
          if (!u.lk[i]) begin rx_ph[i] = 2; streak[i] = 0; waited[i] = 0; end
          else begin rx_t[i]++; if (rx_t[i] == TD) rx_ph[i] = 4; end
        end
        4: if (!u.rds[i]) rx_ph[i] = 5;
        5: if (!u.lk[i]) begin rx_ph[i] = 2; e_loss[i] = 1'b1; streak[i] = 0; waited[i] = 0; end
        default: ;
      endcase
      e_rx_rdy[i] = (old == 5 && rx_ph[i] == 5);
      e_rx_ana[i] = (rx_ph[i] == 0);
      e_rx_dig[i] = (rx_ph[i] < 4);
    end
  endtask

  task automatic compare_outs();
    chk("tx_analogreset",  32'(tx_analogreset),  32'(e_tx_ana));
    chk("tx_digitalreset", 32'(tx_digitalreset), 32'(e_tx_dig));
    chk("tx_ready",        32'(tx_ready),        32'(e_tx_rdy));
    chk("rx_analogreset",  32'(rx_analogreset),  32'(e_rx_ana));
    chk("rx_digitalreset", 32'(rx_digitalreset), 32'(e_rx_dig));
    chk("rx_ready",        32'(rx_ready),        32'(e_rx_rdy));
    chk("rx_lock_loss",    32'(rx_lock_loss),    32'(e_loss));
  endtask

  // Stimulus controls and PHY ack delay lines
  logic [NCH-1:0] h_ta [3], h_td [3], h_ra [3], h_rd [3];
  int lk_low [NCH];
  int tog [NCH];
  bit never [NCH];
  bit rnd;
  int pll_low, tcal_hi;
  int rcal_hi [NCH];
  int cyc, rel0, txr_low, rxr_drop;
  int loss_cnt [NCH];
  int rdy_at [NCH];

  task automatic drive();
    tx_analogreset_stat  = h_ta[2]; tx_digitalreset_stat = h_td[2];
    rx_analogreset_stat  = h_ra[2]; rx_digitalreset_stat = h_rd[2];
    for (int k = 2; k > 0; k--) begin
      h_ta[k] = h_ta[k-1]; h_td[k] = h_td[k-1]; h_ra[k] = h_ra[k-1]; h_rd[k] = h_rd[k-1];
    end
    h_ta[0] = tx_analogreset; h_td[0] = tx_digitalreset;
    h_ra[0] = rx_analogreset; h_rd[0] = rx_digitalreset;
    for (int i = 0; i < NCH; i++) begin
      rx_is_lockedtodata[i] = !(never[i] || lk_low[i] > 0 ||
                                (tog[i] > 0 && ((tog[i] / 10) % 2 == 1)) ||
                                (rnd && $urandom_range(0, 99) < 3));
      if (lk_low[i] > 0) lk_low[i]--;
      if (tog[i] > 0) tog[i]--;
      if (rnd && $urandom_range(0, 499) == 0) rcal_hi[i] = $urandom_range(1, 4);
      rx_cal_busy[i] = (rcal_hi[i] > 0);
      if (rcal_hi[i] > 0) rcal_hi[i]--;
    end
    if (rnd && $urandom_range(0, 499) == 0) pll_low = $urandom_range(1, 4);
    pll_locked = (pll_low == 0);
    if (pll_low > 0) pll_low--;
    tx_cal_busy = (tcal_hi > 0) ? '1 : '0;
    if (tcal_hi > 0) tcal_hi--;
  endtask

  task automatic cycle();
    @(posedge reconfig_clk);
    if (reconfig_reset) model_reset();
    else model_step();
    #1;
    compare_outs();
    cyc++;
    for (int i = 0; i < NCH; i++) begin
      if (rx_lock_loss[i]) loss_cnt[i]++;
      if (rx_ready[i] && rdy_at[i] < 0) rdy_at[i] = cyc - rel0;
    end
    if (!tx_ready) txr_low++;
    if (rx_ready != '1) rxr_drop++;
    drive();
  endtask

  task automatic run(input int n);
    repeat (n) cycle();
  endtask

  task automatic clear_stats();
    txr_low = 0; rxr_drop = 0;
    for (int i = 0; i < NCH; i++) begin loss_cnt[i] = 0; rdy_at[i] = -1; end
    rel0 = cyc;
  endtask

  task automatic release_reset();
    reconfig_reset = 1'b0;
    tcal_hi = 10;
    for (int i = 0; i < NCH; i++) rcal_hi[i] = 10;
    clear_stats();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit reached;
    reconfig_reset = 1'b1;
    pll_locked = 1'b0;
    tx_cal_busy = '1; rx_cal_busy = '1;
    tx_analogreset_stat = '1; tx_digitalreset_stat = '1;
    rx_analogreset_stat = '1; rx_digitalreset_stat = '1;
    rx_is_lockedtodata = '0;
    for (int k = 0; k < 3; k++) begin h_ta[k] = '1; h_td[k] = '1; h_ra[k] = '1; h_rd[k] = '1; end
    for (int i = 0; i < NCH; i++) begin
      lk_low[i] = 0; tog[i] = 0; never[i] = 1'b0; rcal_hi[i] = 0;
    end
    rnd = 1'b0; pll_low = 0; tcal_hi = 0; cyc = 0;
    clear_stats();
    model_reset();
    run(3);
    chk("rst_tx_ready", 32'(tx_ready), 32'd0);
    chk("rst_rx_ana",   32'(rx_analogreset), 32'd3);

    // Nominal bring-up
    release_reset();
    run(200);
    chk("nom_tx_ready", 32'(tx_ready), 32'd1);
    chk("nom_rx_ready", 32'(rx_ready), 32'd3);

    // Lock loss in ready on ch1
    clear_stats();
    lk_low[1] = 5;
    run(100);
    chk("ll_pulses_ch1", 32'(loss_cnt[1]), 32'd1);
    chk("ll_pulses_ch0", 32'(loss_cnt[0]), 32'd0);
    chk("ll_ready_back", 32'(rx_ready), 32'd3);

    // PLL loss while TX ready
    clear_stats();
    pll_low = 3;
    run(100);
    chk("pll_tx_dropped", 32'(txr_low > 0), 32'd1);
    chk("pll_rx_untouched", 32'(rxr_drop), 32'd0);
    chk("pll_tx_back", 32'(tx_ready), 32'd1);

    // ch0 never locks: repeated timeout retries
    clear_stats();
    never[0] = 1'b1;
    run(300);
    chk("tmo_pulses_ch0", 32'(loss_cnt[0] >= 3), 32'd1);
    chk("tmo_ch1_quiet", 32'(loss_cnt[1]), 32'd0);
    chk("tmo_ch1_ready", 32'(rx_ready[1]), 32'd1);
    never[0] = 1'b0;

    // Slow CDR lock on ch1
    reconfig_reset = 1'b1;
    run(3);
    release_reset();
    tog[1] = 40;
    run(200);
    chk("slow_ch0_first", 32'(rdy_at[0] >= 0 && rdy_at[0] < rdy_at[1]), 32'd1);
    chk("slow_ch1_late", 32'(rdy_at[1] >= 40 + LTD), 32'd1);

    // Async reset while TX is in its digital wait
    reconfig_reset = 1'b1;
    run(3);
    release_reset();
    reached = 1'b0;
    for (int n = 0; n < 200 && !reached; n++) begin
      cycle();
      if (tx_ph == 2) reached = 1'b1;
    end
    chk("arst_reached_dig_wait", 32'(reached), 32'd1);
    #2;
    reconfig_reset = 1'b1;
    #1;
    model_reset();
    compare_outs();
    chk("arst_tx_ana", 32'(tx_analogreset), 32'd3);
    chk("arst_tx_dig", 32'(tx_digitalreset), 32'd3);
    run(3);
    release_reset();
    run(200);
    chk("arst_tx_ready", 32'(tx_ready), 32'd1);
    chk("arst_rx_ready", 32'(rx_ready), 32'd3);

    // Random lock, PLL and calibration disturbances
    rnd = 1'b1;
    run(2000);
    rnd = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/sdi_xcvr_reset_seq.md
Name: sdi_xcvr_reset_seq

Overview:
Parametrised N-channel reset sequencer for the SDI H-tile native PHY.
- Drives per-channel tx/rx analog and digital resets.
- Waits on the PHY's *_stat acknowledgements, cal_busy, PLL lock and CDR lock-to-data.
- Provides per-channel ready outputs, lock-loss recovery and lock-timeout retry, which the single-channel PHY integration lacks.
- Sits between system reset and the PHY's reset/status ports; runs on the free-running reconfiguration clock.

Parameters:
- NUM_CH, 1, number of transceiver channels sequenced (1..16).
- T_DIG, 32, cycles held in digital reset after analog reset is released (TX and RX), >=1.
- LTD_CYCLES, 1024, consecutive cycles rx_is_lockedtodata must be high before RX digital release, >=1.
- LOCK_TIMEOUT, 65536, cycles allowed in RX lock wait before a full RX channel retry, > LTD_CYCLES.
- CNT_W, $clog2(LOCK_TIMEOUT+1), counter width (derived, not overridden).

Ports:
- reconfig_clk  in  1  free-running management clock.
- reconfig_reset  in  1  asynchronous, active-high reset.
- pll_locked  in  1  TX PLL lock (asynchronous).
- tx_cal_busy  in  NUM_CH  per-channel TX calibration busy.
- rx_cal_busy  in  NUM_CH  per-channel RX calibration busy.
- tx_analogreset_stat  in  NUM_CH  TX analog reset ack.
- tx_digitalreset_stat  in  NUM_CH  TX digital reset ack.
- rx_analogreset_stat  in  NUM_CH  RX analog reset ack.
- rx_digitalreset_stat  in  NUM_CH  RX digital reset ack.
- rx_is_lockedtodata  in  NUM_CH  CDR lock-to-data.
- tx_analogreset  out  NUM_CH  to PHY.
- tx_digitalreset  out  NUM_CH  to PHY.
- rx_analogreset  out  NUM_CH  to PHY.
- rx_digitalreset  out  NUM_CH  to PHY.
- tx_ready  out  1  all TX channels out of reset.
- rx_ready  out  NUM_CH  per-channel RX out of reset.
- rx_lock_loss  out  NUM_CH  one-cycle pulse on lock loss in RX_READY or on timeout.

Behaviour:
- Clocking/reset: one clock, reconfig_clk. reconfig_reset is asynchronous and active-high.
- Outputs during reset:
  - All *reset outputs = all-ones.
  - tx_ready = 0, rx_ready = 0, rx_lock_loss = 0.
  - All FSMs go to their CAL_WAIT state; counters = 0.
- Input synchronisation: every status input passes through a 2-flop synchroniser. All "sees" below refer to the synchronised value, which adds 2 cycles of latency.
- TX FSM: one shared FSM; all TX channels move together.
  - TX_CAL_WAIT: tx_analogreset = tx_digitalreset = 1. Go to TX_ANA_REL when pll_locked = 1 and all tx_cal_busy = 0.
  - TX_ANA_REL: tx_analogreset = 0. Go to TX_DIG_WAIT when all tx_analogreset_stat = 0.
  - TX_DIG_WAIT: count T_DIG cycles, then go to TX_DIG_REL.
  - TX_DIG_REL: tx_digitalreset = 0. Go to TX_READY when all tx_digitalreset_stat = 0.
  - TX_READY: tx_ready = 1 (registered; first 1 on the cycle after entry).
  - pll_locked = 0 in any state other than TX_CAL_WAIT: next cycle go to TX_CAL_WAIT, reassert both resets, tx_ready = 0.
- RX FSMs: one per channel, fully independent.
  - RX_CAL_WAIT: ana = dig = 1. Go to RX_ANA_REL when rx_cal_busy[i] = 0.
  - RX_ANA_REL: ana = 0. Go to RX_LTD_WAIT when rx_analogreset_stat[i] = 0.
  - RX_LTD_WAIT: dig = 1.
    - Stable counter increments while locked and clears to 0 when unlocked.
    - Timeout counter increments every cycle.
    - Stable counter reaches LTD_CYCLES -> go to RX_DIG_WAIT.
    - Otherwise, timeout counter reaches LOCK_TIMEOUT -> pulse rx_lock_loss[i] and go to RX_CAL_WAIT (analog reset reasserted).
    - If both reach their limits on the same cycle, the stable-counter exit wins.
  - RX_DIG_WAIT: count T_DIG cycles; dropping lock in this state -> back to RX_LTD_WAIT with counters cleared.
  - RX_DIG_REL: dig = 0. Go to RX_READY when rx_digitalreset_stat[i] = 0.
  - RX_READY: rx_ready[i] = 1. Lock loss -> pulse rx_lock_loss[i], dig = 1, rx_ready[i] = 0, go to RX_LTD_WAIT. Analog reset stays released.
  - rx_cal_busy[i] rising in any state -> go to RX_CAL_WAIT.
- Counters saturate; they never wrap.
- Reset mid-sequence: immediate return to the reset values, with no partial release.

Decomposition:
- Package sdi_xcvr_pkg holds:
  - tx_state_t and rx_state_t enums (explicit encodings);
  - SYNC_STAGES = 2;
  - the default timing constants.
- Sub-module sdi_xcvr_rx_rst_fsm: one RX channel (synchroniser inputs, counters, FSM), instantiated NUM_CH times by generate.
- The TX FSM and the all-channel AND/NOR reductions stay in the top level.

Test Plan (NUM_CH=2, T_DIG=8, LTD_CYCLES=16, LOCK_TIMEOUT=64; PHY model acks stat 3 cycles after each reset edge):
- Nominal bring-up:
  - stimulus: reset released, pll_locked = 1, cal_busy dropping at cycle 10, lock held high;
  - response: tx/rx_analogreset fall before digitalreset; digitalreset falls >= 8 cycles after analog stat = 0; tx_ready = 1 and rx_ready = 2'b11 with no glitches.
- Slow CDR lock:
  - stimulus: ch1 lock toggles every 10 cycles for 40 cycles, then held high;
  - response: ch1 released only after 16 consecutive high cycles; ch0 independently ready earlier.
- Timeout retry:
  - stimulus: ch0 never locks;
  - response: rx_lock_loss[0] pulses every ~64 cycles in LTD_WAIT; rx_analogreset[0] reasserts each retry; ch1 unaffected.
- Lock loss in ready:
  - stimulus: ch1 lock drops for 5 cycles after ready;
  - response: one rx_lock_loss[1] pulse; rx_digitalreset[1] = 1 and rx_analogreset[1] stays 0; rx_ready[1] returns after 16 + 8 + ack cycles.
- PLL loss:
  - stimulus: pll_locked drops for 3 cycles while tx_ready = 1;
  - response: tx_ready = 0, both TX resets reasserted, full TX sequence reruns; RX untouched.
- Async reset mid-sequence:
  - stimulus: reconfig_reset pulse during TX_DIG_WAIT;
  - response: all resets = 1 and ready = 0 in the same cycle (asynchronous); sequence restarts cleanly.
